// File: rtl/uart_tx_scheduler_pkg.sv
// uart_pkg: shared definitions for the UART transmit scheduler.
//   state_t      FSM encoding (IDLE / SEND / DONE)
//   FRAME_BITS   serial frame length in bits (10, or 11 with parity)
//   START_BIT / STOP_BIT / IDLE_LEVEL  line levels
//   clog2()      elaboration-time ceiling log2
// Optional feature macro: TX_PARITY_EN (adds an even-parity bit to each frame).
package uart_pkg;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

`ifdef TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  function automatic int clog2(input int v);
    for (int r = 0; r < 32; r++)
      if ((1 << r) >= v) return r;
    return 32;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester-side bus of the UART transmit scheduler.
//   req_valid  per-requester byte available
//   req_data   requester i's byte at [i*DATA_W +: DATA_W]
//   req_ready  one-hot grant from the scheduler
// master = requesters, slave = scheduler.
// A requester must hold req_valid until it sees req_ready; that rule is
// asserted here so every user of the bus gets the check.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8
) (
  input logic clk,
  input logic reset
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold
      a_valid_hold: assert property (@(posedge clk) disable iff (reset)
        (req_valid[i] && !req_ready[i]) |=> req_valid[i]);
    end
  endgenerate

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req        request vector
//   ptr        index of the last winner; search starts at ptr+1
//   enable     gates all grants to zero when low
//   grant      one-hot winner
//   grant_idx  binary index of the winner (0 when no grant)
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]        req,
  input  logic [clog2(NUM_REQ)-1:0] ptr,
  input  logic                      enable,
  output logic [NUM_REQ-1:0]        grant,
  output logic [clog2(NUM_REQ)-1:0] grant_idx
);
  localparam int IDX_W = clog2(NUM_REQ);

  always_comb begin
    int  idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (enable && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin share of one UART transmitter among
// NUM_REQ byte requesters. Each accepted byte is sent as
// start, DATA_W data bits LSB first, [parity,] stop; each bit lasts
// OVERSAMPLE sample_tick pulses.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   sample_tick  oversample strobe (one clk wide)
//   req          requester bus (valid/data/ready), slave side
//   tx_serial    registered serial line, idle high
//   busy         frame in flight (SEND or DONE)
//   grant_id     owner of the current / last frame
//   char_sent    one-clk pulse after the stop bit
// Optional feature macro: TX_PARITY_EN (even parity bit before stop).
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sample_tick,
  uart_tx_scheduler_if.slave        req,
  output logic                      tx_serial,
  output logic                      busy,
  output logic [clog2(NUM_REQ)-1:0] grant_id,
  output logic                      char_sent
);
  localparam int IDX_W  = clog2(NUM_REQ);
  localparam int FB     = FRAME_BITS - 8 + DATA_W;
  localparam int TICK_W = clog2(OVERSAMPLE);
  localparam int BIT_W  = clog2(FB);

  state_t             state, state_nx;
  logic               rst_dly;
  logic [IDX_W-1:0]   rr_ptr, win_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic               arb_en, accept, bit_end, last_tick;
  logic [TICK_W-1:0]  tick_cnt;
  logic [BIT_W-1:0]   bit_idx;
  logic [DATA_W-1:0]  win_data;
  // Frame minus the start bit; the start bit goes straight to tx_serial.
  logic [FB-2:0]      shreg, shreg_ld;

  // rst_dly keeps req_ready low for the first cycle out of reset.
  assign arb_en = (state == IDLE) && !rst_dly && !reset;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req.req_valid),
    .ptr       (rr_ptr),
    .enable    (arb_en),
    .grant     (grant_oh),
    .grant_idx (win_idx)
  );

  // A grant is only ever issued to a valid requester.
  assign accept    = |grant_oh;
  assign win_data  = req.req_data[win_idx*DATA_W +: DATA_W];
  assign bit_end   = sample_tick && (tick_cnt == TICK_W'(OVERSAMPLE-1));
  assign last_tick = bit_end && (bit_idx == BIT_W'(FB-1));

`ifdef TX_PARITY_EN
  assign shreg_ld = {STOP_BIT, ^win_data, win_data};
`else
  assign shreg_ld = {STOP_BIT, win_data};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)    state_nx = SEND;
      SEND:    if (last_tick) state_nx = DONE;
      DONE:                   state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy          = (state != IDLE);
    char_sent     = (state == DONE);
    req.req_ready = grant_oh;
  end

  // Frame timer, shift register and registered line level
  always_ff @(posedge clk) begin
    if (reset) begin
      rst_dly   <= 1'b1;
      tx_serial <= IDLE_LEVEL;
      grant_id  <= '0;
      rr_ptr    <= IDX_W'(NUM_REQ-1);
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '1;
    end else begin
      rst_dly <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          shreg     <= shreg_ld;
          tx_serial <= START_BIT;
          grant_id  <= win_idx;
          rr_ptr    <= win_idx;
          tick_cnt  <= '0;
          bit_idx   <= '0;
        end
        SEND: if (sample_tick) begin
          if (bit_end) begin
            tick_cnt <= '0;
            if (last_tick) begin
              tx_serial <= IDLE_LEVEL;
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              tx_serial <= shreg[0];
              shreg     <= {IDLE_LEVEL, shreg[FB-2:1]};
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: tx_serial <= IDLE_LEVEL;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;
  localparam int NR = 2;
  localparam int DW = 8;
  localparam int OS = 16;
`ifdef TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_tick = 1'b0;
  logic       tx_serial, busy, char_sent;
  logic [0:0] grant_id;

  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW)) rif (.clk(clk), .reset(reset));

  uart_tx_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .OVERSAMPLE(OS)) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .req         (rif),
    .tx_serial   (tx_serial),
    .busy        (busy),
    .grant_id    (grant_id),
    .char_sent   (char_sent)
  );

  typedef struct {
    int         id;
    logic [7:0] data;
    int         bl;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0, errors = 0;
  int   exp_done = 0, done_cnt = 0;
  int   tick_div = 1;
  logic cap [0:1023];
  int   cnt = 0, bad_busy = 0;
  bit   in_frame = 0;
  longint cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference frame, LSB = start bit; bit 10 unused in the 10-bit frame.
  function automatic logic [10:0] mk_frame(input logic [7:0] d);
`ifdef TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {2'b11, d, 1'b0};
`endif
  endfunction

  task automatic push(input int id, input logic [7:0] d, input int bl);
    exp_t e;
    e.id = id; e.data = d; e.bl = bl;
    sbq.push_back(e);
    exp_done++;
  endtask

  // sample_tick: high in cycle k (counted from the last accept edge) when k % tick_div == 0
  initial begin
    logic a;
    int   k;
    k = 0;
    forever begin
      @(negedge clk);
      a = !reset && |(rif.req_valid & rif.req_ready);
      @(posedge clk);
      #1;
      k = a ? 1 : k + 1;
      sample_tick = ((k % tick_div) == 0);
    end
  end

  task automatic finalize();
    exp_t       e;
    logic [10:0] fr;
    logic [7:0] byt;
    int         bad;
    in_frame = 0;
    done_cnt++;
    if (sbq.size() == 0) begin
      chk("unexpected_char_sent", 1, 0);
      return;
    end
    e   = sbq.pop_front();
    fr  = mk_frame(e.data);
    bad = 0;
    chk("grant_id", grant_id, e.id);
    chk("tx_level_in_done", tx_serial, 1);
    chk("busy_in_done", busy, 1);
    chk("frame_cycles", cnt, FB * e.bl);
    chk("busy_during_frame", bad_busy, 0);
    for (int c = 0; c < cnt && c < 1024; c++) begin
      int b;
      b = c / e.bl;
      if (b >= FB || cap[c] !== fr[b]) bad++;
    end
    chk("frame_bit_errors", bad, 0);
    for (int j = 0; j < 8; j++) byt[j] = cap[(j + 1) * e.bl + e.bl / 2];
    chk("decoded_byte", byt, e.data);
  endtask

  // Monitor: captures the line from the cycle after each accept until char_sent.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        in_frame = 0;
      end else begin
        if (in_frame) begin
          if (char_sent) finalize();
          else begin
            if (cnt < 1024) cap[cnt] = tx_serial;
            if (!busy) bad_busy++;
            cnt++;
          end
        end
        if (|(rif.req_valid & rif.req_ready)) begin
          chk("ready_onehot", $onehot(rif.req_ready), 1);
          in_frame = 1;
          cnt      = 0;
          bad_busy = 0;
        end
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 3000 && done_cnt < exp_done; i++) @(negedge clk);
    chk("frames_completed", done_cnt, exp_done);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    rif.req_valid = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send_one(input int id, input logic [7:0] d);
    int n;
    rif.req_data[id*DW +: DW] = d;
    rif.req_valid[id] = 1'b1;
    for (n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (rif.req_ready[id]) break;
    end
    chk("accept_seen", rif.req_ready[id], 1);
    @(posedge clk); #1;
    rif.req_valid[id] = 1'b0;
  endtask

  initial begin
    int     rc [NR];
    longint acc_cyc [2];
    int     na, nbusy;
    rif.req_valid = '0;
    rif.req_data  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Single byte A5, reset state in the first cycle after reset
    rif.req_data[7:0] = 8'hA5;
    rif.req_valid = 2'b01;
    push(0, 8'hA5, OS);
    @(negedge clk);
    chk("rst_tx_serial", tx_serial, 1);
    chk("rst_busy", busy, 0);
    chk("rst_char_sent", char_sent, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_req_ready", rif.req_ready, 0);
    @(negedge clk);
    chk("first_ready", rif.req_ready, 2'b01);
    @(posedge clk); #1 rif.req_valid = '0;
    wait_done();

    // Contention: rotation 0,1,0,1 after reset
    do_reset();
    rif.req_data = {8'h22, 8'h11};
    push(0, 8'h11, OS); push(1, 8'h22, OS); push(0, 8'h11, OS); push(1, 8'h22, OS);
    rc[0] = 0; rc[1] = 0;
    rif.req_valid = 2'b11;
    for (int i = 0; i < 4000 && rif.req_valid != 0; i++) begin
      logic [NR-1:0] acc;
      @(negedge clk);
      acc = rif.req_valid & rif.req_ready;
      for (int r = 0; r < NR; r++) rc[r] += int'(rif.req_ready[r]);
      @(posedge clk); #1;
      for (int r = 0; r < NR; r++) if (acc[r] && rc[r] == 2) rif.req_valid[r] = 1'b0;
    end
    chk("ready_cycles_req0", rc[0], 2);
    chk("ready_cycles_req1", rc[1], 2);
    wait_done();

    // Single requester held: back-to-back grants, DONE + IDLE between frames
    rif.req_data[7:0] = 8'h5A;
    push(0, 8'h5A, OS); push(0, 8'h5A, OS);
    rif.req_valid = 2'b01;
    na = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    for (int i = 0; i < 2000 && na < 2; i++) begin
      @(negedge clk);
      if (rif.req_ready[0]) begin
        acc_cyc[na] = cyc;
        na++;
        if (na == 2) begin @(posedge clk); #1 rif.req_valid = '0; end
      end
    end
    chk("regrant_gap", acc_cyc[1] - acc_cyc[0], FB * OS + 2);
    wait_done();

    // Sparse ticks: one tick every 4 clocks, byte FF
    tick_div = 4;
    push(0, 8'hFF, 4 * OS);
    rif.req_data[7:0] = 8'hFF;
    rif.req_valid = 2'b01;
    nbusy = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      else if (nbusy > 0) break;
      if (rif.req_ready[0]) begin @(posedge clk); #1 rif.req_valid = '0; end
    end
    chk("sparse_busy_cycles", nbusy, FB * 4 * OS + 1);
    wait_done();
    tick_div = 1;

    // Data change after accept does not affect the frame
    rif.req_data[7:0] = 8'h3C;
    push(0, 8'h3C, OS);
    send_one(0, 8'h3C);
    @(posedge clk); #1 rif.req_data[7:0] = 8'hC3;
    wait_done();

    // Parity-sensitive byte (3 ones)
    push(0, 8'h07, OS);
    send_one(0, 8'h07);
    wait_done();

    // Reset mid-frame: frame from requester 1 abandoned, next grant to 0
    rif.req_data[15:8] = 8'h99;
    send_one(1, 8'h99);
    repeat (48) @(posedge clk);
    #1;
    reset = 1'b1;
    rif.req_data[7:0] = 8'h81;
    rif.req_valid = 2'b11;
    push(0, 8'h81, OS);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_tx_serial", tx_serial, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_char_sent", char_sent, 0);
    chk("midrst_ready", rif.req_ready, 0);
    @(negedge clk);
    chk("midrst_next_grant", rif.req_ready, 2'b01);
    @(posedge clk); #1 rif.req_valid[0] = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rif.req_ready[1]) begin @(posedge clk); #1 rif.req_valid[1] = 1'b0; break; end
    end
    push(1, 8'h99, OS);
    wait_done();
    chk("scoreboard_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UART serial transmitter among NUM_REQ byte requesters using round-robin arbitration.
- Sequences each accepted byte as a frame: start bit, 8 data bits LSB-first, stop bit.
- Each bit lasts OVERSAMPLE sample_tick pulses, using the 16x-oversample bit timing of the serial link.
- Sits between game-logic message sources (e.g. player/opponent move encoders) and the serial pin.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_W, 8, bits per character.
- OVERSAMPLE, 16, sample_tick pulses per serial bit (power of two, 2..16).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- sample_tick  input  1  oversample strobe, one clk wide.
- req_valid  input  NUM_REQ  per-requester byte available.
- req_data  input  NUM_REQ*DATA_W  requester i's byte at [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot grant; byte i is accepted when req_valid[i] & req_ready[i].
- tx_serial  output  1  serial line, idle high.
- busy  output  1  high while a frame is in flight (SEND or DONE).
- grant_id  output  clog2(NUM_REQ)  index of the requester owning the current or last frame.
- char_sent  output  1  one-clk pulse after the stop bit completes.

Behaviour:
- Reset values: state=IDLE, tx_serial=1, busy=0, char_sent=0, req_ready=0 for one cycle after reset, grant_id=0, rr_ptr=NUM_REQ-1.
- States: IDLE, SEND, DONE.
- IDLE arbitration:
  - The winner is the first i with req_valid[i]=1, searching rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - req_ready is combinational: one-hot on the winner; all zero when no requester is valid or the state is not IDLE.
- Accept edge: latch req_data of the winner into a shift register; grant_id <= winner; rr_ptr <= winner; tick_cnt <= 0; bit_idx <= 0; state -> SEND.
- SEND:
  - tx_serial = frame[bit_idx], where frame = {1 (stop), data[7:0], 0 (start)} and bit_idx is 0..9.
  - On sample_tick: if tick_cnt == OVERSAMPLE-1, then tick_cnt <= 0 and bit_idx advances; otherwise tick_cnt increments.
  - With no sample_tick, the counters hold.
  - On the last tick of bit 9 (stop bit): state -> DONE.
- DONE: lasts exactly one cycle; char_sent=1, busy=1, tx_serial=1, req_ready=0; state -> IDLE.
- Latency, with sample_tick held high:
  - Start bit occupies cycles 1..OVERSAMPLE after the accept edge.
  - Frame occupies 10*OVERSAMPLE cycles.
  - char_sent is high in cycle 10*OVERSAMPLE+1.
  - The next accept is possible in cycle 10*OVERSAMPLE+2.
- Fairness: a requester holding req_valid waits at most NUM_REQ-1 frames.
- tx_serial is registered: no glitches, no combinational path from req_* to tx_serial.
- Boundary conditions:
  - All requesters valid at once: strict rotation 0,1,…,NUM_REQ-1,0…
  - Single requester valid: it is re-granted back-to-back, with one DONE cycle plus one IDLE cycle between frames.
  - req_valid dropped while not granted: no effect (valid must hold until ready; this is a protocol rule, checked by assertion).
  - Changes to req_data after accept do not affect the frame in flight.
  - sample_tick arriving in the accept cycle is not counted.
  - reset mid-frame: the next edge returns all reset values, the frame is abandoned and no char_sent is issued.
  - reset has priority over every event.

Optional Feature:
- TX_PARITY_EN defined:
  - Frame is 11 bits {stop, parity, data, start}, where parity = XOR of the data bits (even parity).
  - bit_idx runs 0..10; DONE follows the last tick of bit 10.
- TX_PARITY_EN undefined: 10-bit frame as described above; no parity logic is present.

Decomposition:
- Shared package/include uart_pkg holds:
  - State encodings IDLE/SEND/DONE.
  - FRAME_BITS (10, or 11 under TX_PARITY_EN).
  - START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1.
  - clog2 helper function.
- Sub-module rr_arbiter (NUM_REQ parameter): inputs req, ptr, enable; outputs one-hot grant and grant index.
- The frame timer (tick_cnt, bit_idx) stays inline.

Test Plan:
- Single byte: reset, sample_tick=1, req_valid=01, req_data[7:0]=8'hA5 -> tx_serial over 160 cycles is 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; char_sent pulses at cycle 161; grant_id=0.
- Contention: both valid, data0=8'h11, data1=8'h22, held high for 4 frames -> grant order 0,1,0,1; each req_ready is high for exactly one cycle per frame.
- Sparse ticks: sample_tick every 4th clk, byte 8'hFF -> each bit lasts 64 clks; busy stays high for 641 cycles; tx_serial has no glitches.
- Reset at cycle 50 of a frame -> next cycle tx_serial=1, busy=0, no char_sent; next grant goes to requester 0.
- Data change after accept: req_data flips 8'h3C->8'hC3 in cycle 2 -> transmitted bits are still those of 8'h3C.
- Parity (TX_PARITY_EN): byte 8'h07 -> bit 9 = 1, stop at bit 10; char_sent at cycle 177.
